// File: rtl/bht_gshare.sv
// bht_gshare: gshare branch predictor with speculative GHR, mispredict restore and post-reset init sweep
module bht_gshare #(
  parameter int DEPTH = 128,
  parameter int GHR_W = 4,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  output logic             ready,
  input  logic             pred_valid,
  input  logic [31:0]      pred_pc,
  output logic             pred_taken,
  output logic [GHR_W-1:0] pred_ghr,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic [GHR_W-1:0] upd_ghr,
  input  logic             upd_taken,
  input  logic             upd_mispredict
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] WNT = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;
  typedef enum logic {INIT, RUN} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d, pred_idx, upd_idx, wr_idx;
  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic [CNT_W-1:0] cnt_q [DEPTH];
  logic [CNT_W-1:0] upd_cnt, wr_val;
  logic run, rd_taken, wr_en, unused_pc;
  assign run = state_q == RUN;
  assign pred_idx = pred_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
  assign upd_idx = upd_pc[IDX_W+1:2] ^ IDX_W'(upd_ghr);
  assign upd_cnt = cnt_q[upd_idx];
  assign rd_taken = cnt_q[pred_idx][CNT_W-1];
  assign ready = run;
  assign pred_taken = run & rd_taken;
  assign pred_ghr = run ? ghr_q : '0;
  assign unused_pc = ^{pred_pc[31:IDX_W+2], pred_pc[1:0], upd_pc[31:IDX_W+2], upd_pc[1:0]};
  // a mispredict restore replaces the history, discarding any same-cycle speculative shift
  always_comb begin
    state_d = (!run && &ptr_q) ? RUN : state_q;
    ptr_d = run ? ptr_q : ptr_q + IDX_W'(1);
    ghr_d = !run ? ghr_q
          : (upd_valid && upd_mispredict) ? GHR_W'({upd_ghr, upd_taken})
          : pred_valid ? GHR_W'({ghr_q, rd_taken}) : ghr_q;
    wr_en = !reset && (!run || upd_valid);
    wr_idx = run ? upd_idx : ptr_q;
    wr_val = !run ? WNT
           : upd_taken ? (upd_cnt == CMAX ? upd_cnt : upd_cnt + CNT_W'(1))
           : (upd_cnt == '0 ? upd_cnt : upd_cnt - CNT_W'(1));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      ptr_q <= '0;
      ghr_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      ghr_q <= ghr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) cnt_q[wr_idx] <= wr_val;
  end
endmodule
